// File: rtl/jk_register_bank.sv
// jk_register_bank: a bank of WIDTH independent flip-flops that share one clock.
// A run-time mode selects how each bit updates: JK, D, T or SR.
// The bank also has a synchronous parallel load, per-bit change pulses and
// sticky per-bit flags that record an illegal S=R=1 condition.
//
// Ports
//   input_clock1_c_1              clock, rising edge
//   input_input_switch3__clear_3  asynchronous clear, active low
//   preset_n[WIDTH]               per-bit asynchronous preset, active low
//   mode[2]                       00 JK, 01 D, 10 T, 11 SR
//   en                            clock enable
//   j[WIDTH], k[WIDTH]            J/D/T/S and K/R inputs
//   load, load_data[WIDTH]        synchronous parallel load; wins over en
//   illegal_clr                   synchronous clear of the illegal flags
//   q, q_n                        state and its complement
//   changed                       one-cycle pulse for each bit whose q changed on the last edge
//   illegal                       sticky flag, set when S=R=1 is seen in SR mode

module jk_register_bank_lane #(
  parameter int SR_ILLEGAL_HOLD = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_preset_n,
  input  logic [1:0] i_mode,
  input  logic       i_en,
  input  logic       i_j,
  input  logic       i_k,
  input  logic       i_load,
  input  logic       i_load_d,
  input  logic       i_ill_clr,
  output logic       o_q,
  output logic       o_changed,
  output logic       o_illegal
);
  logic r_q, r_changed, r_illegal;
  logic w_next, w_ill_set;

  always_comb begin
    w_next    = r_q;
    w_ill_set = 1'b0;
    if (i_load) begin
      w_next = i_load_d;
    end else if (i_en) begin
      case (i_mode)
        2'b00: begin
          case ({i_j, i_k})
            2'b01:   w_next = 1'b0;
            2'b10:   w_next = 1'b1;
            2'b11:   w_next = ~r_q;
            default: w_next = r_q;
          endcase
        end
        2'b01:   w_next = i_j;
        2'b10:   w_next = r_q ^ i_j;
        default: begin
          if (i_j && i_k) begin
            w_next    = (SR_ILLEGAL_HOLD != 0) ? r_q : 1'b0;
            w_ill_set = 1'b1;
          end else if (i_j) begin
            w_next = 1'b1;
          end else if (i_k) begin
            w_next = 1'b0;
          end
        end
      endcase
    end
  end

  // State flop with asynchronous clear and preset. Clear has priority.
  always_ff @(posedge i_clk or negedge i_rst_n or negedge i_preset_n) begin
    if (!i_rst_n)         r_q <= 1'b0;
    else if (!i_preset_n) r_q <= 1'b1;
    else                  r_q <= w_next;
  end

  // Preset does not reach these flops asynchronously. A bit that is held in
  // preset at a clock edge ignores that edge, so its illegal flag keeps its
  // value and its change pulse reads 0 (q cannot move while it is preset).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_changed <= 1'b0;
      r_illegal <= 1'b0;
    end else if (!i_preset_n) begin
      r_changed <= 1'b0;
    end else begin
      r_changed <= w_next ^ r_q;
      // A new illegal event beats illegal_clr on the same edge.
      if (w_ill_set)      r_illegal <= 1'b1;
      else if (i_ill_clr) r_illegal <= 1'b0;
    end
  end

  assign o_q       = r_q;
  assign o_changed = r_changed;
  assign o_illegal = r_illegal;
endmodule

module jk_register_bank #(
  parameter int WIDTH           = 4,
  parameter int SR_ILLEGAL_HOLD = 1
) (
  input  logic             input_clock1_c_1,
  input  logic             input_input_switch3__clear_3,
  input  logic [WIDTH-1:0] preset_n,
  input  logic [1:0]       mode,
  input  logic             en,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             illegal_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic [WIDTH-1:0] changed,
  output logic [WIDTH-1:0] illegal
);
  logic [WIDTH-1:0] w_q;

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    jk_register_bank_lane #(.SR_ILLEGAL_HOLD(SR_ILLEGAL_HOLD)) u_lane (
      .i_clk      (input_clock1_c_1),
      .i_rst_n    (input_input_switch3__clear_3),
      .i_preset_n (preset_n[g]),
      .i_mode     (mode),
      .i_en       (en),
      .i_j        (j[g]),
      .i_k        (k[g]),
      .i_load     (load),
      .i_load_d   (load_data[g]),
      .i_ill_clr  (illegal_clr),
      .o_q        (w_q[g]),
      .o_changed  (changed[g]),
      .o_illegal  (illegal[g])
    );
  end

  assign q   = w_q;
  assign q_n = ~w_q;
endmodule
